alu_seq_ctrl: RTL and testbench

Registered, parametrised ALU control sequencer that replaces the purely combinational ALUOp/opType decoder. It decodes each issued instruction into a final ALU operation code and drives the ALU enable and operand-feedback controls. Variable-amount shifts execute as repeated single-bit ALU shifts over several cycles, with a ready/valid issue handshake back to the decode stage. It sits between instruction decode and the ALU, and stalls decode while a multi-cycle operation is in flight.

---
 rtl/alu_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Registered ALU control sequencer: decodes issued instructions into ALU codes and
// runs variable shifts as repeated single-bit ALU shifts with a ready/valid handshake.
module alu_seq_ctrl #(
  parameter int OPW = 3,
  parameter int SAW = 3
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           issue_valid,
  output logic           issue_ready,
  input  logic [2:0]     ALUOp,
  input  logic [1:0]     opType,
  input  logic [SAW-1:0] shamt,
  output logic [OPW-1:0] ALUOpFinal,
  output logic           alu_en,
  output logic           feedback_sel,
  output logic           done,
  output logic           illegal
);

  // state | meaning
  // IDLE  | no instruction in flight, outputs parked at NOP
  // EXEC  | executing; rem = cycles left including the current one
  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [2:0] C_ADD  = 3'b000;
  localparam logic [2:0] C_SUB  = 3'b001;
  localparam logic [2:0] C_SRL1 = 3'b010;
  localparam logic [2:0] C_SLL1 = 3'b011;
  localparam logic [2:0] C_XOR  = 3'b100;
  localparam logic [2:0] C_XORR = 3'b101;
  localparam logic [2:0] C_AND  = 3'b110;
  localparam logic [2:0] C_NOP  = 3'b111;

  state_t         state, state_n;
  logic [SAW-1:0] rem, rem_n;
  logic [OPW-1:0] op_n;
  logic           en_n, fb_n, done_n, ill_n;

  logic [2:0]     dec_code;
  logic [SAW-1:0] dec_cnt;
  logic           dec_en, dec_ill;
  logic           accept;

  always_comb begin
    dec_code = C_NOP;
    dec_cnt  = SAW'(1);
    dec_en   = 1'b1;
    dec_ill  = 1'b0;
    case (ALUOp)
      3'b000: begin
        case (opType)
          2'b00:   dec_code = C_ADD;
          2'b01:   dec_code = C_XOR;
          2'b10:   dec_code = C_XORR;
          default: dec_code = C_AND;
        endcase
      end
      3'b001: dec_code = C_SUB;
      3'b010, 3'b011: begin
        // zero-length shift still takes one cycle so done keeps its meaning
        if (shamt == '0) begin
          dec_code = C_NOP;
          dec_en   = 1'b0;
        end else begin
          dec_code = (ALUOp == 3'b010) ? C_SRL1 : C_SLL1;
          dec_cnt  = shamt;
        end
      end
      3'b100, 3'b101: dec_code = C_ADD;
      3'b110: begin
        dec_code = C_NOP;
        dec_en   = 1'b0;
      end
      default: begin
        case (opType)
          2'b01:   dec_code = C_SUB;
          2'b11: begin
            dec_code = C_NOP;
            dec_en   = 1'b0;
            dec_ill  = 1'b1;
          end
          default: dec_code = C_ADD;
        endcase
      end
    endcase
  end

  assign issue_ready = (state == IDLE) || (rem == SAW'(1));
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    op_n    = ALUOpFinal;
    en_n    = alu_en;
    fb_n    = feedback_sel;
    done_n  = 1'b0;
    ill_n   = 1'b0;
    if (accept) begin
      state_n = EXEC;
      rem_n   = dec_cnt;
      op_n    = OPW'(dec_code);
      en_n    = dec_en;
      fb_n    = 1'b0;
      done_n  = (dec_cnt == SAW'(1));
      ill_n   = dec_ill;
    end else if (state == EXEC && rem != SAW'(1)) begin
      rem_n  = rem - SAW'(1);
      fb_n   = 1'b1;
      done_n = (rem == SAW'(2));
    end else if (state == EXEC) begin
      state_n = IDLE;
      rem_n   = '0;
      op_n    = OPW'(C_NOP);
      en_n    = 1'b0;
      fb_n    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      rem          <= '0;
      ALUOpFinal   <= OPW'(C_NOP);
      alu_en       <= 1'b0;
      feedback_sel <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      state        <= state_n;
      rem          <= rem_n;
      ALUOpFinal   <= op_n;
      alu_en       <= en_n;
      feedback_sel <= fb_n;
      done         <= done_n;
      illegal      <= ill_n;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: fixed decode vectors, hand-written reset and shift sequences,
// and back-to-back/random instruction streams checked against a per-cycle trace model.
module tb_alu_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic       issue_ready;
  logic [2:0] ALUOp = '0;
  logic [1:0] opType = '0;
  logic [2:0] shamt = '0;
  logic [2:0] ALUOpFinal;
  logic       alu_en, feedback_sel, done, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_ctrl #(.OPW(3), .SAW(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ALUOp(ALUOp), .opType(opType), .shamt(shamt),
    .ALUOpFinal(ALUOpFinal), .alu_en(alu_en), .feedback_sel(feedback_sel),
    .done(done), .illegal(illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] a;
    logic [1:0] t;
    logic [2:0] s;
  } instr_t;

  typedef struct packed {
    logic [2:0] op;
    logic       en;
    logic       fb;
    logic       dn;
    logic       il;
  } exp_t;

  typedef struct {
    logic [2:0] a;
    logic [1:0] t;
    logic [2:0] s;
    logic [2:0] op;
    int         cyc;
    bit         en;
    bit         il;
  } vec_t;

  localparam exp_t IDLE_OUT = '{op: 3'b111, en: 1'b0, fb: 1'b0, dn: 1'b0, il: 1'b0};

  instr_t     instr_q[$];
  exp_t       exp_q[$];
  vec_t       vecs[$];
  logic [2:0] sub0_codes [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {ALUOpFinal, alu_en, feedback_sel, done, illegal};
  endfunction

  // Reference decode straight from the opcode table: code, cycle count, enable, illegal.
  function automatic void model_decode(input instr_t in, output logic [2:0] code,
                                       output int cyc, output bit en, output bit il);
    code = 3'b000; cyc = 1; en = 1'b1; il = 1'b0;
    if (in.a == 3'd0) code = sub0_codes[in.t];
    else if (in.a == 3'd1) code = 3'b001;
    else if (in.a == 3'd2 || in.a == 3'd3) begin
      if (in.s == 0) begin code = 3'b111; en = 1'b0; end
      else begin code = in.a; cyc = int'(in.s); end
    end else if (in.a == 3'd6) begin code = 3'b111; en = 1'b0; end
    else if (in.a == 3'd7) begin
      if (in.t == 2'd3) begin code = 3'b111; en = 1'b0; il = 1'b1; end
      else if (in.t == 2'd1) code = 3'b001;
    end
  endfunction

  function automatic void model_push(input instr_t in);
    logic [2:0] code; int cyc; bit en, il;
    model_decode(in, code, cyc, en, il);
    for (int i = 1; i <= cyc; i++)
      exp_q.push_back('{op: code, en: en, fb: (i > 1), dn: (i == cyc), il: (il && i == cyc)});
  endfunction

  task automatic drive_junk(input bit v);
    ALUOp = 3'($urandom_range(7));
    opType = 2'($urandom_range(3));
    shamt = 3'($urandom_range(7));
    issue_valid = v;
  endtask

  // Issues instr_q as fast as the model says the sequencer is ready; while busy, the
  // inputs carry junk (sometimes with valid high) that must be ignored.
  task automatic run_stream(input string name, input int gap_pct);
    int idx = 0;
    int guard = 0;
    bit drove, mready;
    exp_t e;
    exp_q.delete();
    @(negedge Clk);
    while ((idx < instr_q.size() || exp_q.size() > 0) && guard < 5000) begin
      guard++;
      mready = (exp_q.size() <= 1);
      e = (exp_q.size() > 0) ? exp_q[0] : IDLE_OUT;
      check(name, {outs(), issue_ready}, {e, mready});
      drove = 1'b0;
      if (mready && idx < instr_q.size() && $urandom_range(99) >= gap_pct) begin
        ALUOp = instr_q[idx].a; opType = instr_q[idx].t; shamt = instr_q[idx].s;
        issue_valid = 1'b1;
        drove = 1'b1;
      end else begin
        drive_junk(mready ? 1'b0 : 1'($urandom_range(1)));
      end
      @(posedge Clk);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (drove) begin
        model_push(instr_q[idx]);
        idx++;
      end
      @(negedge Clk);
    end
    issue_valid = 1'b0;
    check({name, "_timeout"}, (guard >= 5000), 0);
    check({name, "_idle"}, {outs(), issue_ready}, {IDLE_OUT, 1'b1});
    instr_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0;
    @(negedge Clk);
    ALUOp = v.a; opType = v.t; shamt = v.s; issue_valid = 1'b1;
    @(posedge Clk);
    #1 drive_junk(1'b0);
    @(negedge Clk);
    while (cyc < 20) begin
      cyc++;
      check("vec_op", ALUOpFinal, v.op);
      check("vec_en", alu_en, v.en);
      check("vec_fb", feedback_sel, (cyc > 1));
      if (done) begin
        check("vec_ill", illegal, v.il);
        check("vec_rdy_last", issue_ready, 1);
        break;
      end
      check("vec_rdy_busy", {issue_ready, illegal}, 2'b00);
      @(negedge Clk);
    end
    check("vec_cycles", cyc, v.cyc);
    @(negedge Clk);
    check("vec_idle", {outs(), issue_ready}, {IDLE_OUT, 1'b1});
  endtask

  initial begin
    sub0_codes = '{3'b000, 3'b100, 3'b101, 3'b110};
    vecs.push_back('{3'b000, 2'b00, 3'd3, 3'b000, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b000, 2'b10, 3'd0, 3'b101, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b000, 2'b11, 3'd1, 3'b110, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 2'b10, 3'd4, 3'b001, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b011, 2'b00, 3'd5, 3'b011, 5, 1'b1, 1'b0});
    vecs.push_back('{3'b010, 2'b01, 3'd7, 3'b010, 7, 1'b1, 1'b0});
    vecs.push_back('{3'b010, 2'b00, 3'd0, 3'b111, 1, 1'b0, 1'b0});
    vecs.push_back('{3'b011, 2'b11, 3'd2, 3'b011, 2, 1'b1, 1'b0});
    vecs.push_back('{3'b101, 2'b01, 3'd6, 3'b000, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b110, 2'b00, 3'd2, 3'b111, 1, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 2'b11, 3'd1, 3'b111, 1, 1'b0, 1'b1});
    vecs.push_back('{3'b111, 2'b01, 3'd0, 3'b001, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b111, 2'b10, 3'd3, 3'b000, 1, 1'b1, 1'b0});

    // reset held with valid high: outputs stay parked, nothing is accepted
    issue_valid = 1'b1; ALUOp = 3'b000; opType = 2'b00; shamt = 3'd1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_outs", outs(), IDLE_OUT);
    issue_valid = 1'b0;
    Reset_n = 1'b1;
    #1 check("rst_ready", issue_ready, 1);
    @(negedge Clk);
    check("rst_no_accept", {outs(), issue_ready}, {IDLE_OUT, 1'b1});

    foreach (vecs[i]) run_vec(vecs[i]);

    for (int a = 0; a < 8; a++)
      for (int t = 0; t < 4; t++)
        instr_q.push_back('{a: 3'(a), t: 2'(t), s: 3'd1});
    run_stream("sweep", 0);

    instr_q.push_back('{a: 3'b010, t: 2'b00, s: 3'd3});
    instr_q.push_back('{a: 3'b000, t: 2'b01, s: 3'd0});
    run_stream("b2b_srl_xor", 0);

    // reset lands on cycle 2 of a shift by 6, between clock edges
    @(negedge Clk);
    ALUOp = 3'b010; opType = 2'b00; shamt = 3'd6; issue_valid = 1'b1;
    @(posedge Clk);
    #1 issue_valid = 1'b0;
    @(negedge Clk);
    check("mid_c1", {outs(), issue_ready}, {3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 check("mid_async_rst", outs(), IDLE_OUT);
    @(negedge Clk);
    check("mid_rst_held", outs(), IDLE_OUT);
    Reset_n = 1'b1;
    ALUOp = 3'b000; opType = 2'b00; shamt = 3'd0; issue_valid = 1'b1;
    #1 check("mid_ready", issue_ready, 1);
    @(posedge Clk);
    #1 issue_valid = 1'b0;
    @(negedge Clk);
    check("mid_add", {outs(), issue_ready}, {3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    @(negedge Clk);
    check("mid_idle", outs(), IDLE_OUT);

    for (int i = 0; i < 150; i++)
      instr_q.push_back('{a: 3'($urandom_range(7)), t: 2'($urandom_range(3)),
                          s: 3'($urandom_range(7))});
    run_stream("random", 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
